// File: rtl/street_light_controller.sv
// rtl/street_light_controller.sv - dark-sensing lamp enable FSM with registered clock divider.
// Optional input debounce via STREET_LIGHT_DEBOUNCE_EN.
module street_light_controller #(
    parameter int DIV_RATIO       = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk_in,
    input  logic reset,
    input  logic light_sensor,
    output logic street_light,
    output logic clk_out
);

    localparam int HALF = DIV_RATIO / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (DIV_RATIO < 2 || (DIV_RATIO % 2) != 0) begin : g_bad_div_ratio
            $error("DIV_RATIO must be even and >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic {
        ST_DAY   = 1'b0,
        ST_NIGHT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_sensor_q;
    logic            r_street_light;
    logic            r_clk_out;
    logic [CW-1:0]   r_div_cnt;
    logic            w_div_tc;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sensor_q <= 1'b0;
        end else begin
            r_sensor_q <= light_sensor;
        end
    end

`ifdef STREET_LIGHT_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DBW-1:0] r_db_cnt;
    logic           w_db_diff;
    logic           w_db_done;

    assign w_db_diff = (state_t'(r_sensor_q) != r_state);
    assign w_db_done = w_db_diff && (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1));

    // Any sample agreeing with the current state restarts the stability window.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_db_cnt <= '0;
        end else if (!w_db_diff || w_db_done) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_db_done) begin
            w_next_state = state_t'(r_sensor_q);
        end
    end
`else
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_DAY:   if (r_sensor_q)  w_next_state = ST_NIGHT;
            ST_NIGHT: if (!r_sensor_q) w_next_state = ST_DAY;
            default:  w_next_state = ST_DAY;
        endcase
    end
`endif

    // Lamp decodes the next state so it moves on the same edge as the FSM.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state        <= ST_DAY;
            r_street_light <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_street_light <= (w_next_state == ST_NIGHT);
        end
    end

    assign w_div_tc = (r_div_cnt == CW'(HALF - 1));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_clk_out <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_clk_out <= ~r_clk_out;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign street_light = r_street_light;
    assign clk_out      = r_clk_out;

endmodule

// File: tb/tb_street_light_controller.sv
// tb/tb_street_light_controller.sv - scoreboard bench for street_light_controller.
module tb_street_light_controller;

    localparam int DIV_RATIO       = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int HALF            = DIV_RATIO / 2;

    logic clk_in = 1'b0;
    logic reset;
    logic light_sensor;
    logic street_light;
    logic clk_out;

    street_light_controller #(
        .DIV_RATIO       (DIV_RATIO),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .light_sensor (light_sensor),
        .street_light (street_light),
        .clk_out      (clk_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic sl;
        logic co;
        int   idx;
    } exp_t;

    exp_t  sb[$];
    logic  hist[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    k      = 0;
    int    n_edge = 0;
    int    n_rise = 0;
    logic  prev_co = 1'b0;

    function automatic void check(string name, int idx, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0b expected %0b", name, idx, act, exp);
        end
    endfunction

    // Lamp seen after the latest edge, derived from sample history since reset release.
    function automatic logic model_lamp();
`ifdef STREET_LIGHT_DEBOUNCE_EN
        logic st;
        int   run;
        st  = 1'b0;
        run = 0;
        for (int m = 2; m <= hist.size(); m++) begin
            if (hist[m-2] != st) begin
                run++;
                if (run == DEBOUNCE_CYCLES) begin
                    st  = hist[m-2];
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
        return st;
`else
        if (hist.size() < 2) return 1'b0;
        return hist[hist.size()-2];
`endif
    endfunction

    task automatic do_edge(input logic s);
        exp_t e;
        light_sensor = s;
        @(posedge clk_in);
        #1;
        hist.push_back(s);
        k++;
        n_edge++;
        e.sl  = model_lamp();
        e.co  = logic'((k / HALF) % 2);
        e.idx = n_edge;
        sb.push_back(e);
        if (k <= 38 && clk_out && !prev_co) n_rise++;
        prev_co = clk_out;
        if (k == 38) check("clk_out_rises_by_38", n_edge, (n_rise == 10), 1'b1);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        #2;
        reset   = 1'b0;
        hist.delete();
        k       = 0;
        n_rise  = 0;
        prev_co = 1'b0;
    endtask

    task automatic random_runs(input int n);
        int   left;
        logic v;
        left = n;
        while (left > 0) begin
            int len;
            len = $urandom_range(1, 12);
            v   = logic'($urandom_range(0, 1));
            for (int i = 0; i < len && left > 0; i++) begin
                do_edge(v);
                left--;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("street_light", e.idx, street_light, e.sl);
                check("clk_out", e.idx, clk_out, e.co);
            end
        end
    end

    initial begin : stimulus
        reset        = 1'b1;
        light_sensor = 1'b0;
        #1;
        check("reset_street_light", 0, street_light, 1'b0);
        check("reset_clk_out", 0, clk_out, 1'b0);
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_hold_clk_out", 0, clk_out, 1'b0);
        release_reset();

        repeat (6)  do_edge(1'b0);
        repeat (12) do_edge(1'b1);
        do_edge(1'b0);
        repeat (11) do_edge(1'b0);
        repeat (12) do_edge(1'b1);
        for (int i = 0; i < 10; i++) do_edge(logic'(i % 2));
        repeat (10) do_edge(1'b0);
        repeat (3)  do_edge(1'b1);
        repeat (12) do_edge(1'b0);
        random_runs(60);
        repeat (12) do_edge(1'b1);

        @(negedge clk_in);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_street_light", n_edge, street_light, 1'b0);
        check("async_reset_clk_out", n_edge, clk_out, 1'b0);
        repeat (2) @(posedge clk_in);
        release_reset();
        repeat (12) do_edge(1'b1);
        random_runs(60);
        repeat (12) do_edge(1'b0);

        @(negedge clk_in);
        #1;
        check("scoreboard_drained", n_edge, (sb.size() == 0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
